// File: rtl/io_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_bridge_pkg
// Purpose  : Shared types and constants for the memory-mapped I/O bus bridge.
// Revision : 1.0 - initial release
// ============================================================================
package io_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } io_bridge_state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Eight 32-bit window bases, 0x7f00 + i*256, port 0 in the low word.
    localparam logic [255:0] c_default_bases = {
        32'h0000_8600, 32'h0000_8500, 32'h0000_8400, 32'h0000_8300,
        32'h0000_8200, 32'h0000_8100, 32'h0000_8000, 32'h0000_7f00
    };

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : io_addr_decode
// Purpose  : Window decoder; lowest-indexed matching port wins on overlap.
// Revision : 1.0 - initial release
// ============================================================================
module io_addr_decode
    import io_bridge_pkg::*;
#(
    parameter int                          NUM_PORTS  = 4,
    parameter int                          ADDR_W     = 32,
    parameter int                          REGION_AW  = 8,
    parameter logic [NUM_PORTS*ADDR_W-1:0] BASE_ADDRS = c_default_bases[NUM_PORTS*ADDR_W-1:0],
    parameter int                          IDX_W      = clog2_min1(NUM_PORTS)
) (
    input  logic [ADDR_W-REGION_AW-1:0] page_i,
    output logic                        hit_o,
    output logic [NUM_PORTS-1:0]        sel_o,
    output logic [IDX_W-1:0]            idx_o
);

    logic [NUM_PORTS-1:0] w_match;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_match
        assign w_match[i] =
            (page_i == BASE_ADDRS[i*ADDR_W+REGION_AW +: ADDR_W-REGION_AW]);
    end

    assign hit_o = |w_match;

    // Walk from the top so the lowest matching index overwrites the rest.
    always_comb begin
        sel_o = '0;
        idx_o = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                sel_o    = '0;
                sel_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_bridge
// Purpose  : Stalling request/ack bridge from the data-memory port to I/O ports.
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_bridge
    import io_bridge_pkg::*;
#(
    parameter int                          NUM_PORTS      = 4,
    parameter int                          DATA_W         = 32,
    parameter int                          ADDR_W         = 32,
    parameter int                          REGION_AW      = 8,
    parameter logic [NUM_PORTS*ADDR_W-1:0] BASE_ADDRS     = c_default_bases[NUM_PORTS*ADDR_W-1:0],
    parameter int                          TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           address,
    input  logic                        MemRead,
    input  logic                        MemWrite,
    input  logic [DATA_W-1:0]           io_memory_write,
    output logic [DATA_W-1:0]           io_memory_read,
    output logic                        valid_io_read,
    output logic                        io_stall,
    output logic                        bus_error,
    output logic [NUM_PORTS-1:0]        p_sel,
    output logic                        p_wr,
    output logic [REGION_AW-1:0]        p_addr,
    output logic [DATA_W-1:0]           p_wdata,
    input  logic [NUM_PORTS*DATA_W-1:0] p_rdata,
    input  logic [NUM_PORTS-1:0]        p_ack
);

    localparam int               IDX_W    = clog2_min1(NUM_PORTS);
    localparam int               CNT_W    = clog2_min1(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    io_bridge_state_t       state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_PORTS-1:0]   sel_q, sel_d;
    logic                   wr_q, wr_d;
    logic [REGION_AW-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   w_hit;
    logic [NUM_PORTS-1:0]   w_dec_sel;
    logic [IDX_W-1:0]       w_dec_idx;
    logic                   w_ack;
    logic [DATA_W-1:0]      w_port_rdata;

    io_addr_decode #(
        .NUM_PORTS  (NUM_PORTS),
        .ADDR_W     (ADDR_W),
        .REGION_AW  (REGION_AW),
        .BASE_ADDRS (BASE_ADDRS),
        .IDX_W      (IDX_W)
    ) u_decode (
        .page_i (address[ADDR_W-1:REGION_AW]),
        .hit_o  (w_hit),
        .sel_o  (w_dec_sel),
        .idx_o  (w_dec_idx)
    );

    // Only the latched port can complete the access; other acks are strays.
    assign w_ack        = p_ack[idx_q];
    assign w_port_rdata = p_rdata[int'(idx_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sel_d         = sel_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        io_stall      = 1'b0;
        valid_io_read = 1'b0;

        case (state_q)
            IDLE: begin
                if ((MemRead || MemWrite) && w_hit) begin
                    io_stall = 1'b1;
                    idx_d    = w_dec_idx;
                    sel_d    = w_dec_sel;
                    wr_d     = MemWrite;
                    addr_d   = address[REGION_AW-1:0];
                    wdata_d  = io_memory_write;
                    cnt_d    = '0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                io_stall = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (w_ack) begin
                    if (!wr_q) begin
                        rdata_d = w_port_rdata;
                    end
                    sel_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    if (!wr_q) begin
                        rdata_d = DATA_W'(ERR_DATA);
                    end
                    err_d   = 1'b1;
                    sel_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Unconditional return to IDLE keeps the held request from re-issuing.
                valid_io_read = !wr_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io_memory_read = rdata_q;
    assign bus_error      = err_q;
    assign p_sel          = sel_q;
    assign p_wr           = wr_q;
    assign p_addr         = addr_q;
    assign p_wdata        = wdata_q;

endmodule
`default_nettype wire
